// File: rtl/mesh_result_drain.sv
// -----------------------------------------------------------------------------
// mesh_result_drain
//
// Read side of the 2x2 mesh matrix multiplier. Watches the controller's
// STM/EOM handshake. When a product completes (rising edge of EOM), it captures
// the four result registers. It then streams them out one word per transfer on
// a valid/ready port.
//
// Parameters
//   W      result word width in bits
//   ORDER  0 = row-major    (C11, C12, C21, C22)
//          1 = column-major (C11, C21, C12, C22)
//
// Ports
//   CLK   in   1     clock, all logic on rising edge
//   RST   in   1     synchronous active-high reset
//   STM   in   1     multiply start (same net as the controller's)
//   EOM   in   1     end of multiply; 1 idle, 0 while computing
//   CIN   in   4*W   result registers {C22,C21,C12,C11}, C11 in [W-1:0]
//   ODAT  out  W     output word (0 whenever OVLD is low)
//   OVLD  out  1     ODAT valid
//   ORDY  in   1     downstream ready
//   OLST  out  1     last (4th) word of a product
//   BUSY  out  1     a product is held or being drained
//   OVR   out  1     sticky overrun flag
//   CLRO  in   1     clears OVR (a simultaneous overrun wins)
//   RCNT  out  8     products fully delivered, wraps 255 -> 0
// -----------------------------------------------------------------------------
module mesh_result_drain #(
  parameter int W     = 16,
  parameter int ORDER = 0
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           STM,
  input  logic           EOM,
  input  logic [4*W-1:0] CIN,
  output logic [W-1:0]   ODAT,
  output logic           OVLD,
  input  logic           ORDY,
  output logic           OLST,
  output logic           BUSY,
  output logic           OVR,
  input  logic           CLRO,
  output logic [7:0]     RCNT
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic         eom_q;
  logic [1:0]   idx_q, idx_d;
  logic         ovr_q, ovr_d;
  logic [7:0]   rcnt_q, rcnt_d;
  logic [W-1:0] buf_q [4];

  logic         done;
  logic         busy;
  logic         accept;
  logic         capture;

  // Map the transfer index to the buffer slot (slot 0..3 = C11,C12,C21,C22).
  // Column-major order is simply the index with its two bits swapped.
  function automatic logic [1:0] slot_of(input logic [1:0] idx);
    logic [1:0] s;
    if (ORDER == 1) s = {idx[0], idx[1]};
    else            s = idx;
    return s;
  endfunction

  // EOM_d resets to 1 so that leaving reset with EOM high is not a completion.
  assign done   = EOM & ~eom_q;
  assign busy   = (state_q == S_DRAIN);
  assign accept = busy & ORDY;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ovr_d   = ovr_q;
    rcnt_d  = rcnt_q;
    capture = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // A completion outranks a new start; EOM may already have been low.
        if (done) begin
          capture = 1'b1;
          idx_d   = 2'd0;
          state_d = S_DRAIN;
        end else if (STM) begin
          state_d = S_ARMED;
        end
      end
      S_ARMED: begin
        if (done) begin
          capture = 1'b1;
          idx_d   = 2'd0;
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (accept) begin
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            rcnt_d  = rcnt_q + 8'd1;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A completion while busy is dropped and flagged; set outranks clear.
    if (done && busy)  ovr_d = 1'b1;
    else if (CLRO)     ovr_d = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      eom_q   <= 1'b1;
      idx_q   <= 2'd0;
      ovr_q   <= 1'b0;
      rcnt_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      eom_q   <= EOM;
      idx_q   <= idx_d;
      ovr_q   <= ovr_d;
      rcnt_q  <= rcnt_d;
    end
  end

  // Result buffer: data only, loaded on the capture edge and otherwise held.
  always_ff @(posedge CLK) begin
    if (capture) begin
      for (int k = 0; k < 4; k++) begin
        buf_q[k] <= CIN[k*W +: W];
      end
    end
  end

  // Outputs are decoded from registered state, so they are stable under stall.
  assign OVLD = busy;
  assign BUSY = busy;
  assign OLST = busy && (idx_q == 2'd3);
  assign ODAT = busy ? buf_q[slot_of(idx_q)] : '0;
  assign OVR  = ovr_q;
  assign RCNT = rcnt_q;

endmodule

// File: tb/tb_mesh_result_drain.sv
module tb_mesh_result_drain;

  localparam int W = 16;

  logic           CLK = 1'b0;
  logic           RST, STM, EOM, ORDY, CLRO;
  logic [4*W-1:0] CIN;

  logic [W-1:0]   ODAT0, ODAT1;
  logic           OVLD0, OVLD1, OLST0, OLST1, BUSY0, BUSY1, OVR0, OVR1;
  logic [7:0]     RCNT0, RCNT1;

  int checks = 0;
  int errors = 0;
  int exp_rcnt = 0;

  always #5 CLK = ~CLK;

  mesh_result_drain #(.W(W), .ORDER(0)) dut0 (
    .CLK(CLK), .RST(RST), .STM(STM), .EOM(EOM), .CIN(CIN),
    .ODAT(ODAT0), .OVLD(OVLD0), .ORDY(ORDY), .OLST(OLST0),
    .BUSY(BUSY0), .OVR(OVR0), .CLRO(CLRO), .RCNT(RCNT0)
  );

  mesh_result_drain #(.W(W), .ORDER(1)) dut1 (
    .CLK(CLK), .RST(RST), .STM(STM), .EOM(EOM), .CIN(CIN),
    .ODAT(ODAT1), .OVLD(OVLD1), .ORDY(ORDY), .OLST(OLST1),
    .BUSY(BUSY1), .OVR(OVR1), .CLRO(CLRO), .RCNT(RCNT1)
  );

  // Advance one clock; outputs are then read 1 time unit after the edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // STM pulse, EOM low four cycles, then EOM high through the capture edge.
  task automatic run_product(input logic [4*W-1:0] c);
    CIN = c;
    STM = 1'b1;
    tick();
    STM = 1'b0;
    EOM = 1'b0;
    repeat (4) tick();
    EOM = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    RST = 1'b1; STM = 1'b0; EOM = 1'b1; ORDY = 1'b0; CLRO = 1'b0; CIN = '0;
    repeat (3) tick();
    checks++;
    if (OVLD0 !== 1'b0 || OLST0 !== 1'b0 || BUSY0 !== 1'b0 || OVR0 !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: ovld=%b olst=%b busy=%b ovr=%b, required all 0",
               OVLD0, OLST0, BUSY0, OVR0);
    end
    checks++;
    if (ODAT0 !== 16'd0 || RCNT0 !== 8'd0) begin
      errors++;
      $display("FAIL reset_data: odat=%0d rcnt=%0d, required 0 0", ODAT0, RCNT0);
    end
    RST = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (OVLD0 !== 1'b0 || OVLD1 !== 1'b0) begin
        errors++;
        $display("FAIL reset_release_ovld cycle %0d: ovld=%b/%b, required 0", i, OVLD0, OVLD1);
      end
    end
  endtask

  task automatic test_basic();
    logic [W-1:0] want;
    ORDY = 1'b1;
    run_product({16'd4, 16'd3, 16'd2, 16'd1});
    for (int i = 0; i < 4; i++) begin
      want = W'(i + 1);
      checks++;
      if (OVLD0 !== 1'b1 || BUSY0 !== 1'b1 || ODAT0 !== want || OLST0 !== (i == 3)) begin
        errors++;
        $display("FAIL basic_word%0d: ovld=%b busy=%b odat=%0d olst=%b, required 1 1 %0d %b",
                 i, OVLD0, BUSY0, ODAT0, OLST0, want, (i == 3));
      end
      tick();
    end
    exp_rcnt++;
    checks++;
    if (OVLD0 !== 1'b0 || BUSY0 !== 1'b0 || RCNT0 !== 8'(exp_rcnt)) begin
      errors++;
      $display("FAIL basic_end: ovld=%b busy=%b rcnt=%0d, required 0 0 %0d",
               OVLD0, BUSY0, RCNT0, exp_rcnt);
    end
  endtask

  task automatic test_order();
    logic [W-1:0] exp_col [4];
    exp_col[0] = 16'd1; exp_col[1] = 16'd3; exp_col[2] = 16'd2; exp_col[3] = 16'd4;
    ORDY = 1'b1;
    run_product({16'd4, 16'd3, 16'd2, 16'd1});
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (OVLD1 !== 1'b1 || ODAT1 !== exp_col[i] || OLST1 !== (i == 3)) begin
        errors++;
        $display("FAIL order_col_word%0d: ovld=%b odat=%0d olst=%b, required 1 %0d %b",
                 i, OVLD1, ODAT1, OLST1, exp_col[i], (i == 3));
      end
      tick();
    end
    exp_rcnt++;
    checks++;
    if (OVLD1 !== 1'b0 || RCNT1 !== 8'(exp_rcnt) || RCNT0 !== 8'(exp_rcnt)) begin
      errors++;
      $display("FAIL order_end: ovld=%b rcnt=%0d/%0d, required 0 %0d", OVLD1, RCNT1, RCNT0, exp_rcnt);
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] want;
    ORDY = 1'b0;
    run_product({16'd4, 16'd3, 16'd2, 16'd1});
    // ORDY alternates 0,1 starting on the first valid cycle: 8 cycles total.
    for (int k = 0; k < 8; k++) begin
      want = W'(k / 2 + 1);
      checks++;
      if (OVLD0 !== 1'b1 || ODAT0 !== want || OLST0 !== (k >= 6)) begin
        errors++;
        $display("FAIL bp_cycle%0d: ovld=%b odat=%0d olst=%b, required 1 %0d %b",
                 k, OVLD0, ODAT0, OLST0, want, (k >= 6));
      end
      ORDY = k[0];
      tick();
    end
    ORDY = 1'b0;
    exp_rcnt++;
    checks++;
    if (OVLD0 !== 1'b0 || RCNT0 !== 8'(exp_rcnt)) begin
      errors++;
      $display("FAIL bp_end: ovld=%b rcnt=%0d, required 0 %0d", OVLD0, RCNT0, exp_rcnt);
    end
  endtask

  task automatic test_overrun();
    logic [W-1:0] want;
    ORDY = 1'b0;
    run_product({16'd4, 16'd3, 16'd2, 16'd1});
    EOM = 1'b0;
    repeat (2) tick();
    CIN = {16'd8, 16'd7, 16'd6, 16'd5};
    EOM = 1'b1;
    tick();
    checks++;
    if (OVR0 !== 1'b1 || OVLD0 !== 1'b1 || BUSY0 !== 1'b1 || ODAT0 !== 16'd1) begin
      errors++;
      $display("FAIL ovr_set: ovr=%b ovld=%b busy=%b odat=%0d, required 1 1 1 1",
               OVR0, OVLD0, BUSY0, ODAT0);
    end
    CIN = {16'hdead, 16'hbeef, 16'h1234, 16'h5678};
    repeat (3) tick();
    checks++;
    if (ODAT0 !== 16'd1 || OVLD0 !== 1'b1) begin
      errors++;
      $display("FAIL ovr_stall_hold: odat=%0d ovld=%b, required 1 1", ODAT0, OVLD0);
    end
    for (int i = 0; i < 4; i++) begin
      want = W'(i + 1);
      checks++;
      if (ODAT0 !== want || OVLD0 !== 1'b1) begin
        errors++;
        $display("FAIL ovr_drain_word%0d: odat=%0d ovld=%b, required %0d 1", i, ODAT0, OVLD0, want);
      end
      ORDY = 1'b1;
      tick();
    end
    ORDY = 1'b0;
    exp_rcnt++;
    tick();
    checks++;
    if (OVLD0 !== 1'b0 || RCNT0 !== 8'(exp_rcnt) || OVR0 !== 1'b1) begin
      errors++;
      $display("FAIL ovr_after_drain: ovld=%b rcnt=%0d ovr=%b, required 0 %0d 1",
               OVLD0, RCNT0, OVR0, exp_rcnt);
    end
    CLRO = 1'b1;
    tick();
    CLRO = 1'b0;
    checks++;
    if (OVR0 !== 1'b0) begin
      errors++;
      $display("FAIL ovr_clear: ovr=%b, required 0", OVR0);
    end
  endtask

  task automatic test_boundary();
    ORDY = 1'b1;
    run_product({16'd4, 16'd3, 16'd2, 16'd1});
    EOM = 1'b0;
    repeat (3) tick();
    checks++;
    if (OLST0 !== 1'b1 || ODAT0 !== 16'd4) begin
      errors++;
      $display("FAIL edge_last_word: olst=%b odat=%0d, required 1 4", OLST0, ODAT0);
    end
    // Completion arrives on the same edge the last word is accepted, with CLRO.
    CIN = {16'd9, 16'd9, 16'd9, 16'd9};
    EOM = 1'b1;
    CLRO = 1'b1;
    tick();
    CLRO = 1'b0;
    exp_rcnt++;
    checks++;
    if (OVR0 !== 1'b1 || OVLD0 !== 1'b0 || RCNT0 !== 8'(exp_rcnt)) begin
      errors++;
      $display("FAIL edge_overrun: ovr=%b ovld=%b rcnt=%0d, required 1 0 %0d",
               OVR0, OVLD0, RCNT0, exp_rcnt);
    end
    tick();
    checks++;
    if (OVLD0 !== 1'b0 || BUSY0 !== 1'b0) begin
      errors++;
      $display("FAIL edge_no_capture: ovld=%b busy=%b, required 0 0", OVLD0, BUSY0);
    end
    CLRO = 1'b1;
    tick();
    CLRO = 1'b0;
    checks++;
    if (OVR0 !== 1'b0) begin
      errors++;
      $display("FAIL edge_clear: ovr=%b, required 0", OVR0);
    end
  endtask

  task automatic test_reset_mid_drain();
    logic [W-1:0] want;
    ORDY = 1'b1;
    run_product({16'd4, 16'd3, 16'd2, 16'd1});
    repeat (2) tick();
    checks++;
    if (ODAT0 !== 16'd3 || OVLD0 !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_pre: odat=%0d ovld=%b, required 3 1", ODAT0, OVLD0);
    end
    RST = 1'b1;
    tick();
    RST = 1'b0;
    exp_rcnt = 0;
    checks++;
    if (OVLD0 !== 1'b0 || BUSY0 !== 1'b0 || ODAT0 !== 16'd0 || RCNT0 !== 8'd0) begin
      errors++;
      $display("FAIL rst_mid_state: ovld=%b busy=%b odat=%0d rcnt=%0d, required 0 0 0 0",
               OVLD0, BUSY0, ODAT0, RCNT0);
    end
    run_product({16'd40, 16'd30, 16'd20, 16'd10});
    for (int i = 0; i < 4; i++) begin
      want = W'(10 * (i + 1));
      checks++;
      if (OVLD0 !== 1'b1 || ODAT0 !== want) begin
        errors++;
        $display("FAIL rst_next_word%0d: ovld=%b odat=%0d, required 1 %0d", i, OVLD0, ODAT0, want);
      end
      tick();
    end
    exp_rcnt++;
    checks++;
    if (OVLD0 !== 1'b0 || RCNT0 !== 8'(exp_rcnt)) begin
      errors++;
      $display("FAIL rst_next_end: ovld=%b rcnt=%0d, required 0 %0d", OVLD0, RCNT0, exp_rcnt);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_order();
    test_backpressure();
    test_overrun();
    test_boundary();
    test_reset_mid_drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
